// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared widths, address field offsets and sequencer state encoding
//
// Purpose: common constants for the MLP layer sequencer and its index counter.
//   Address layout is {layer[1:0], neuron[3:0], in_idx[9:0]}; the bias memory
//   only looks at the upper {layer, neuron} field (bits [15:10]).
// Ports: none (package).

package mlp_pkg;

  localparam int ADDR_W     = 16;
  localparam int LAYER_W    = 2;
  localparam int NEURON_W   = 4;
  localparam int IDX_W      = 10;
  localparam int IDX_LSB    = 0;
  localparam int NEURON_LSB = 10;
  localparam int LAYER_LSB  = 14;
  localparam int MAX_LAYERS = 4;
  localparam int ACT_ADDR_W = LAYER_W + NEURON_W;
  localparam int STATE_W    = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_MAC  = 3'd1;
  localparam logic [STATE_W-1:0] S_BIAS = 3'd2;
  localparam logic [STATE_W-1:0] S_ADD  = 3'd3;
  localparam logic [STATE_W-1:0] S_WB   = 3'd4;
  localparam logic [STATE_W-1:0] S_FIN  = 3'd5;

  // Builds the packed weight/bias address from its three fields.
  function automatic logic [ADDR_W-1:0] pack_addr(
    input logic [LAYER_W-1:0]  layer,
    input logic [NEURON_W-1:0] neuron,
    input logic [IDX_W-1:0]    in_idx
  );
    logic [ADDR_W-1:0] a;
    a = '0;
    a[LAYER_LSB  +: LAYER_W]  = layer;
    a[NEURON_LSB +: NEURON_W] = neuron;
    a[IDX_LSB    +: IDX_W]    = in_idx;
    return a;
  endfunction

endpackage

// File: rtl/mlp_idx_counter.sv
// rtl/mlp_idx_counter.sv - nested input/neuron/layer index counter with terminal flags
//
// Purpose: holds the k (input index), n (neuron) and l (layer) counters of the
//   sequencer. Terminal-count flags are looked up from the packed per-layer
//   LAYER_IN / LAYER_OUT parameters using the current layer.
// Ports:
//   clk_i      in   clock
//   reset_i    in   synchronous active-high reset, clears all counters
//   clr_i      in   clear all counters (pass start / pass end)
//   inc_k_i    in   advance the input index
//   adv_i      in   move to the next neuron, or the next layer after the last neuron
//   k_o        out  input index
//   n_o        out  neuron index
//   l_o        out  layer index
//   k_last_o   out  k is the last input of the current layer
//   n_last_o   out  n is the last neuron of the current layer
//   l_last_o   out  l is the last layer

module mlp_idx_counter
  import mlp_pkg::*;
#(
  parameter int unsigned                  N_LAYERS  = 3,
  parameter logic [N_LAYERS*IDX_W-1:0]    LAYER_IN  = {10'd2, 10'd2, 10'd2},
  parameter logic [N_LAYERS*NEURON_W-1:0] LAYER_OUT = {4'd1, 4'd2, 4'd2}
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clr_i,
  input  logic                inc_k_i,
  input  logic                adv_i,
  output logic [IDX_W-1:0]    k_o,
  output logic [NEURON_W-1:0] n_o,
  output logic [LAYER_W-1:0]  l_o,
  output logic                k_last_o,
  output logic                n_last_o,
  output logic                l_last_o
);

  logic [IDX_W-1:0]    k_q, k_d;
  logic [NEURON_W-1:0] n_q, n_d;
  logic [LAYER_W-1:0]  l_q, l_d;
  logic [IDX_W-1:0]    k_lim;
  logic [NEURON_W-1:0] n_lim;

  // Per-layer sizes for the layer currently being walked.
  always_comb begin
    k_lim = '0;
    n_lim = '0;
    for (int j = 0; j < int'(N_LAYERS); j++) begin
      if (l_q == LAYER_W'(j)) begin
        k_lim = LAYER_IN[j*IDX_W +: IDX_W];
        n_lim = LAYER_OUT[j*NEURON_W +: NEURON_W];
      end
    end
  end

  assign k_last_o = (k_q == k_lim - IDX_W'(1));
  assign n_last_o = (n_q == n_lim - NEURON_W'(1));
  assign l_last_o = (l_q == LAYER_W'(N_LAYERS - 1));

  // Advancing past the last neuron of the last layer holds the counters;
  // the FSM never asks for that and clears them on the way back to idle.
  always_comb begin
    k_d = k_q;
    n_d = n_q;
    l_d = l_q;
    if (clr_i) begin
      k_d = '0;
      n_d = '0;
      l_d = '0;
    end else if (adv_i) begin
      k_d = '0;
      if (!n_last_o) begin
        n_d = n_q + NEURON_W'(1);
      end else if (!l_last_o) begin
        n_d = '0;
        l_d = l_q + LAYER_W'(1);
      end
    end else if (inc_k_i) begin
      k_d = k_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      k_q <= '0;
      n_q <= '0;
      l_q <= '0;
    end else begin
      k_q <= k_d;
      n_q <= n_d;
      l_q <= l_d;
    end
  end

  assign k_o = k_q;
  assign n_o = n_q;
  assign l_o = l_q;

endmodule

// File: rtl/mlp_layer_sequencer.sv
// rtl/mlp_layer_sequencer.sv - sequences one MLP inference pass over layers, neurons and inputs
//
// Purpose: walks every (layer, neuron, input) triple, drives the shared
//   weight/bias address and strobes the MAC, bias-add and activation-write
//   datapath. Neurons are processed strictly one after another, so a layer only
//   reads activations after the previous layer's final write.
// Ports:
//   clk_i        in   1   clock, rising edge
//   reset_i      in   1   synchronous active-high reset; aborts a pass immediately
//   start_i      in   1   start a pass; only sampled while idle
//   busy_o       out  1   pass in progress (not asserted in the done cycle)
//   done_o       out  1   one-cycle pulse after the last activation write
//   mem_addr_o   out  16  {layer, neuron, in_idx} weight/bias address
//   mac_clr_o    out  1   clear accumulator, with the first mac_en of a neuron
//   mac_en_o     out  1   weight/input at memory outputs valid, accumulate
//   bias_add_o   out  1   bias value valid, add to accumulator
//   act_we_o     out  1   write ReLU(accumulator) to the activation buffer
//   act_addr_o   out  6   activation write address {layer, neuron}

module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int unsigned                  N_LAYERS  = 3,
  parameter logic [N_LAYERS*IDX_W-1:0]    LAYER_IN  = {10'd2, 10'd2, 10'd2},
  parameter logic [N_LAYERS*NEURON_W-1:0] LAYER_OUT = {4'd1, 4'd2, 4'd2}
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_W-1:0]     mem_addr_o,
  output logic                  mac_clr_o,
  output logic                  mac_en_o,
  output logic                  bias_add_o,
  output logic                  act_we_o,
  output logic [ACT_ADDR_W-1:0] act_addr_o
);

  // Parameter legality. Field widths already cap inputs at 1023 and neurons at 15.
  if (N_LAYERS < 1 || N_LAYERS > MAX_LAYERS) begin : g_bad_layers
    $error("mlp_layer_sequencer: N_LAYERS must be 1..4");
  end
  for (genvar g = 0; g < int'(N_LAYERS); g++) begin : g_chk
    if (LAYER_IN[g*IDX_W +: IDX_W] == '0) begin : g_bad_in
      $error("mlp_layer_sequencer: LAYER_IN entry must be 1..1023");
    end
    if (LAYER_OUT[g*NEURON_W +: NEURON_W] == '0) begin : g_bad_out
      $error("mlp_layer_sequencer: LAYER_OUT entry must be 1..15");
    end
  end

  state_t state_q, state_d;
  logic   mac_en_q, mac_en_d;
  logic   mac_clr_q, mac_clr_d;

  logic                cnt_clr;
  logic                cnt_inc_k;
  logic                cnt_adv;
  logic [IDX_W-1:0]    k;
  logic [NEURON_W-1:0] n;
  logic [LAYER_W-1:0]  l;
  logic                k_last;
  logic                n_last;
  logic                l_last;

  mlp_idx_counter #(
    .N_LAYERS  (N_LAYERS),
    .LAYER_IN  (LAYER_IN),
    .LAYER_OUT (LAYER_OUT)
  ) u_idx (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clr_i    (cnt_clr),
    .inc_k_i  (cnt_inc_k),
    .adv_i    (cnt_adv),
    .k_o      (k),
    .n_o      (n),
    .l_o      (l),
    .k_last_o (k_last),
    .n_last_o (n_last),
    .l_last_o (l_last)
  );

  always_comb begin
    state_d   = state_q;
    cnt_clr   = 1'b0;
    cnt_inc_k = 1'b0;
    cnt_adv   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_MAC;
          cnt_clr = 1'b1;
        end
      end
      S_MAC: begin
        if (k_last) begin
          state_d = S_BIAS;
        end else begin
          cnt_inc_k = 1'b1;
        end
      end
      S_BIAS: state_d = S_ADD;
      S_ADD:  state_d = S_WB;
      S_WB: begin
        if (n_last && l_last) begin
          state_d = S_FIN;
        end else begin
          cnt_adv = 1'b1;
          state_d = S_MAC;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_clr = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The weight memory answers one cycle after an address is presented, so the
  // MAC strobes are the "address valid" condition delayed by one cycle. That
  // puts the final mac_en of a neuron in the BIAS cycle.
  assign mac_en_d  = (state_q == S_MAC);
  assign mac_clr_d = (state_q == S_MAC) && (k == '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mac_en_q  <= mac_en_d;
      mac_clr_q <= mac_clr_d;
    end
  end

  // BIAS presents the {layer, neuron} field so the registered bias memory
  // output is ready in ADD; the address is then held through WB.
  always_comb begin
    mem_addr_o = '0;
    case (state_q)
      S_MAC:               mem_addr_o = pack_addr(l, n, k);
      S_BIAS, S_ADD, S_WB: mem_addr_o = pack_addr(l, n, '0);
      default:             mem_addr_o = '0;
    endcase
  end

  assign busy_o     = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done_o     = (state_q == S_FIN);
  assign mac_en_o   = mac_en_q;
  assign mac_clr_o  = mac_clr_q;
  assign bias_add_o = (state_q == S_ADD);
  assign act_we_o   = (state_q == S_WB);
  assign act_addr_o = (state_q == S_WB) ? {l, n} : '0;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// tb/tb_mlp_layer_sequencer.sv - self-checking bench for mlp_layer_sequencer

module tb_mlp_layer_sequencer;
  import mlp_pkg::*;

  localparam logic [29:0] LIN_A  = {10'd2, 10'd2, 10'd2};
  localparam logic [11:0] LOUT_A = {4'd1, 4'd2, 4'd2};
  localparam logic [29:0] LIN_B  = {10'd1, 10'd1, 10'd1};
  localparam logic [11:0] LOUT_B = {4'd1, 4'd1, 4'd1};

  logic        clk = 1'b0;
  logic        start_v    [2];
  logic        reset_v    [2];
  logic        busy_v     [2];
  logic        done_v     [2];
  logic        mac_clr_v  [2];
  logic        mac_en_v   [2];
  logic        bias_add_v [2];
  logic        act_we_v   [2];
  logic [15:0] mem_addr_v [2];
  logic [5:0]  act_addr_v [2];
  logic [15:0] bias_val   [2];

  always #5 clk = ~clk;

  mlp_layer_sequencer #(.N_LAYERS(3), .LAYER_IN(LIN_A), .LAYER_OUT(LOUT_A)) u_a (
    .clk_i(clk), .reset_i(reset_v[0]), .start_i(start_v[0]), .busy_o(busy_v[0]),
    .done_o(done_v[0]), .mem_addr_o(mem_addr_v[0]), .mac_clr_o(mac_clr_v[0]),
    .mac_en_o(mac_en_v[0]), .bias_add_o(bias_add_v[0]), .act_we_o(act_we_v[0]),
    .act_addr_o(act_addr_v[0])
  );

  mlp_layer_sequencer #(.N_LAYERS(3), .LAYER_IN(LIN_B), .LAYER_OUT(LOUT_B)) u_b (
    .clk_i(clk), .reset_i(reset_v[1]), .start_i(start_v[1]), .busy_o(busy_v[1]),
    .done_o(done_v[1]), .mem_addr_o(mem_addr_v[1]), .mac_clr_o(mac_clr_v[1]),
    .mac_en_o(mac_en_v[1]), .bias_add_o(bias_add_v[1]), .act_we_o(act_we_v[1]),
    .act_addr_o(act_addr_v[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int inst, input int c,
                     input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst %0d cycle %0d: got %0h expected %0h", nm, inst, c, got, exp);
    end
  endtask

  // Expected per-cycle trace of one pass, index = cycles after the start edge.
  logic [15:0] t_addr [2][64];
  bit          t_achk [2][64];
  bit          t_busy [2][64];
  bit          t_done [2][64];
  bit          t_clr  [2][64];
  bit          t_en   [2][64];
  bit          t_bias [2][64];
  bit          t_we   [2][64];
  logic [5:0]  t_act  [2][64];
  int          t_len  [2];

  task automatic build_trace(input int i, input int nl, input logic [39:0] lin_p,
                             input logic [15:0] lout_p);
    bit is_mac [64];
    bit is_first [64];
    int c;
    int kk;
    int nn;
    for (int j = 0; j < 64; j++) begin
      t_addr[i][j] = '0; t_achk[i][j] = 0; t_busy[i][j] = 0; t_done[i][j] = 0;
      t_clr[i][j] = 0; t_en[i][j] = 0; t_bias[i][j] = 0; t_we[i][j] = 0;
      t_act[i][j] = '0; is_mac[j] = 0; is_first[j] = 0;
    end
    c = 1;
    for (int l = 0; l < nl; l++) begin
      kk = int'(lin_p[l*10 +: 10]);
      nn = int'(lout_p[l*4 +: 4]);
      for (int n = 0; n < nn; n++) begin
        for (int k = 0; k < kk; k++) begin
          t_addr[i][c] = {l[1:0], n[3:0], k[9:0]};
          t_achk[i][c] = 1; t_busy[i][c] = 1; is_mac[c] = 1; is_first[c] = (k == 0);
          c++;
        end
        t_addr[i][c] = {l[1:0], n[3:0], 10'd0}; t_achk[i][c] = 1; t_busy[i][c] = 1;
        c++;
        t_addr[i][c] = {l[1:0], n[3:0], 10'd0}; t_achk[i][c] = 1; t_busy[i][c] = 1;
        t_bias[i][c] = 1;
        c++;
        t_busy[i][c] = 1; t_we[i][c] = 1; t_act[i][c] = {l[1:0], n[3:0]};
        c++;
      end
    end
    t_done[i][c] = 1;
    t_len[i] = c;
    // Weight data follows its address by one cycle.
    for (int j = 2; j <= c; j++) begin
      t_en[i][j]  = is_mac[j-1];
      t_clr[i][j] = is_mac[j-1] && is_first[j-1];
    end
  endtask

  // Bias memory: registered read of the {layer, neuron} field.
  logic [15:0] tbl [64];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) bias_val[i] <= tbl[mem_addr_v[i][15:10]];
  end

  // Pass tracking: a pass starts when start is seen while idle.
  int cyc = 0;
  int s_cyc [2];
  bit act [2];
  bit chk_en = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (reset_v[i]) begin
        act[i] <= 0;
      end else if ((!act[i] || (cyc - s_cyc[i] > t_len[i])) && start_v[i]) begin
        act[i]   <= 1;
        s_cyc[i] <= cyc;
      end
    end
  end

  logic [5:0]  q_act [$];
  logic [15:0] q_first [$];
  logic [15:0] prev_addr0 = '0;
  logic [15:0] seen17 = '0;
  logic [15:0] seen32 = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 2; i++) begin
          int  o;
          bit  in_pass;
          o = cyc - s_cyc[i];
          in_pass = act[i] && o >= 1 && o <= t_len[i];
          if (!in_pass) o = 0;
          chk("busy",     i, cyc, busy_v[i],     in_pass && t_busy[i][o]);
          chk("done",     i, cyc, done_v[i],     in_pass && t_done[i][o]);
          chk("mac_clr",  i, cyc, mac_clr_v[i],  in_pass && t_clr[i][o]);
          chk("mac_en",   i, cyc, mac_en_v[i],   in_pass && t_en[i][o]);
          chk("bias_add", i, cyc, bias_add_v[i], in_pass && t_bias[i][o]);
          chk("act_we",   i, cyc, act_we_v[i],   in_pass && t_we[i][o]);
          if (in_pass && t_achk[i][o]) chk("mem_addr", i, cyc, mem_addr_v[i], t_addr[i][o]);
          if (in_pass && t_we[i][o])   chk("act_addr", i, cyc, act_addr_v[i], t_act[i][o]);
          if (in_pass && t_bias[i][o])
            chk("bias_val", i, cyc, bias_val[i], tbl[t_addr[i][o-1][15:10]]);
        end
        if (act_we_v[0]) q_act.push_back(act_addr_v[0]);
        if (mac_clr_v[0]) q_first.push_back(prev_addr0);
        if (bias_add_v[0] && mem_addr_v[0][15:10] == 6'd17) seen17 = bias_val[0];
        if (bias_add_v[0] && mem_addr_v[0][15:10] == 6'd32) seen32 = bias_val[0];
        prev_addr0 = mem_addr_v[0];
      end
    end
  end

  logic [15:0] obs_addr [128];
  bit          obs_en   [128];
  bit          obs_clr  [128];
  bit          obs_bias [128];
  bit          obs_we   [128];
  logic [5:0]  obs_act  [128];
  logic [2:0]  obs_st   [128];

  task automatic run_pass(input int i, input bit inj, input int rst_at,
                          output int done_n, output int busy_n);
    done_n = -1;
    busy_n = 0;
    q_act.delete();
    q_first.delete();
    @(posedge clk); #1 start_v[i] = 1'b1;
    @(posedge clk); #1 start_v[i] = 1'b0;
    for (int n = 1; n < 100; n++) begin
      @(negedge clk);
      obs_addr[n] = mem_addr_v[i]; obs_en[n] = mac_en_v[i]; obs_clr[n] = mac_clr_v[i];
      obs_bias[n] = bias_add_v[i]; obs_we[n] = act_we_v[i]; obs_act[n] = act_addr_v[i];
      obs_st[n] = (i == 0) ? u_a.state_q : u_b.state_q;
      if (busy_v[i]) busy_n++;
      if (rst_at > 0 && n == rst_at + 1) begin
        chk("rst_mem_addr", i, n, mem_addr_v[i], 0);
        chk("rst_busy",     i, n, busy_v[i], 0);
        chk("rst_strobes",  i, n, {done_v[i], mac_clr_v[i], mac_en_v[i], bias_add_v[i], act_we_v[i]}, 0);
        chk("rst_act_addr", i, n, act_addr_v[i], 0);
        chk("rst_state",    i, n, obs_st[n], S_IDLE);
        reset_v[i] = 1'b0;
        done_n = 0;
        break;
      end
      if (done_v[i]) begin
        done_n = n;
        break;
      end
      start_v[i] = inj && (n == 2 || n == 5);
      if (n == rst_at) reset_v[i] = 1'b1;
    end
    start_v[i] = 1'b0;
  endtask

  task automatic check_seq_a(input string tag);
    logic [5:0]  exp_act [5];
    logic [15:0] exp_first [5];
    exp_act   = '{6'h00, 6'h01, 6'h10, 6'h11, 6'h20};
    exp_first = '{16'h0000, 16'h0400, 16'h4000, 16'h4400, 16'h8000};
    chk({tag, "_act_cnt"}, 0, 0, q_act.size(), 5);
    chk({tag, "_first_cnt"}, 0, 0, q_first.size(), 5);
    for (int j = 0; j < 5; j++) begin
      if (j < q_act.size())   chk({tag, "_act_addr"}, 0, j, q_act[j], exp_act[j]);
      if (j < q_first.size()) chk({tag, "_first_addr"}, 0, j, q_first[j], exp_first[j]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    int bn;
    for (int j = 0; j < 64; j++) tbl[j] = 16'(j * 5 + 1);
    tbl[17] = 16'd73;
    tbl[32] = 16'd112;
    start_v[0] = 0; start_v[1] = 0;
    reset_v[0] = 1; reset_v[1] = 1;
    build_trace(0, 3, {10'd0, LIN_A}, {4'd0, LOUT_A});
    build_trace(1, 3, {10'd0, LIN_B}, {4'd0, LOUT_B});
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_mem_addr", 0, cyc, mem_addr_v[0], 0);
    chk("reset_busy",     0, cyc, busy_v[0], 0);
    chk("reset_strobes",  0, cyc, {done_v[0], mac_clr_v[0], mac_en_v[0], bias_add_v[0], act_we_v[0]}, 0);
    chk("reset_act_addr", 0, cyc, act_addr_v[0], 0);
    chk("reset_state",    0, cyc, u_a.state_q, S_IDLE);
    chk_en = 1;
    reset_v[0] = 0; reset_v[1] = 0;

    // First pass: opening cycles, full sequence, done timing, bias values.
    seen17 = '0; seen32 = '0;
    run_pass(0, 0, 0, dn, bn);
    chk("t1_addr_c1", 0, 1, obs_addr[1], 16'h0000);
    chk("t1_addr_c2", 0, 2, obs_addr[2], 16'h0001);
    chk("t1_mac_en_c2_c3", 0, 2, {obs_en[2], obs_en[3], obs_en[4]}, 3'b110);
    chk("t1_mac_clr_c2", 0, 2, {obs_clr[2], obs_clr[3]}, 2'b10);
    chk("t1_bias_add_c4", 0, 4, obs_bias[4], 1);
    chk("t1_act_we_c5", 0, 5, {obs_we[5], obs_act[5]}, {1'b1, 6'h00});
    chk("t2_done_cycle", 0, 0, dn, 26);
    chk("t2_busy_cycles", 0, 0, bn, 25);
    check_seq_a("t2");
    chk("t6_bias_l1n1", 0, 0, seen17, 73);
    chk("t6_bias_l2n0", 0, 0, seen32, 112);

    // Start raised during MAC and WB is ignored; back-to-back start after done.
    run_pass(0, 1, 0, dn, bn);
    chk("t3_done_cycle", 0, 0, dn, 26);
    check_seq_a("t3");
    run_pass(0, 0, 0, dn, bn);
    chk("t3b_done_cycle", 0, 0, dn, 26);
    check_seq_a("t3b");

    // Reset mid layer-0 neuron 1, then a clean pass.
    run_pass(0, 0, 8, dn, bn);
    run_pass(0, 0, 0, dn, bn);
    chk("t4_done_cycle", 0, 0, dn, 26);
    chk("t4_busy_cycles", 0, 0, bn, 25);
    check_seq_a("t4");

    // Single-input layers: MAC strobes land in the BIAS cycle.
    run_pass(1, 0, 0, dn, bn);
    chk("t5_done_cycle", 1, 0, dn, 13);
    chk("t5_busy_cycles", 1, 0, bn, 12);
    chk("t5_clr_en_c2", 1, 2, {obs_clr[2], obs_en[2], obs_st[2]}, {2'b11, S_BIAS});
    chk("t5_clr_en_c6", 1, 6, {obs_clr[6], obs_en[6], obs_st[6]}, {2'b11, S_BIAS});
    chk("t5_en_c3", 1, 3, obs_en[3], 0);
    chk("t5_act_we_c4", 1, 4, {obs_we[4], obs_act[4]}, {1'b1, 6'h00});

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
